// File: rtl/stepper_phase_decoder.sv
// -----------------------------------------------------------------------------
// stepper_phase_decoder
//
// Receive-side monitor for a 4-bit stepper coil drive bus. The coil pattern is
// synchronised, glitch filtered, and every newly accepted pattern is classified
// as a clockwise/counter-clockwise full or half step, or as a fault. A signed
// position is kept in half-step units.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active low
//   coil_in      coil pattern {A,C,B,D}; may be asynchronous to clk
//   clear_pos    synchronous clear of the position counter (wins over a step)
//   position     signed half-step position, wraps modulo 2^POS_W
//   step_pulse   one-cycle pulse per counted step
//   dir_cw       direction of the last counted step (1 = clockwise)
//   half_mode    1 if the last counted step was a half step
//   locked       a valid reference pattern is held
//   fault        one-cycle pulse on an invalid pattern or ambiguous transition
//   fault_count  saturating number of faults since reset
// -----------------------------------------------------------------------------
module stepper_phase_decoder #(
    parameter int POS_W      = 16,
    parameter int STABLE_CYC = 4,
    parameter int FCNT_W     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              coil_in,
    input  logic                    clear_pos,
    output logic signed [POS_W-1:0] position,
    output logic                    step_pulse,
    output logic                    dir_cw,
    output logic                    half_mode,
    output logic                    locked,
    output logic                    fault,
    output logic [FCNT_W-1:0]       fault_count
);

    localparam int CNT_W = $clog2(STABLE_CYC + 1);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_e;

    // Maps a coil code to {valid, index}; index follows the clockwise order.
    function automatic logic [3:0] decode(input logic [3:0] code);
        logic [3:0] res;
        case (code)
            4'b1000: res = 4'b1_000;  // A
            4'b1010: res = 4'b1_001;  // AB
            4'b0010: res = 4'b1_010;  // B
            4'b0110: res = 4'b1_011;  // BC
            4'b0100: res = 4'b1_100;  // C
            4'b0101: res = 4'b1_101;  // CD
            4'b0001: res = 4'b1_110;  // D
            4'b1001: res = 4'b1_111;  // DA
            default: res = 4'b0_000;
        endcase
        return res;
    endfunction

    // Input path: two-stage synchroniser, then a stability filter.
    logic [3:0]       sync1_q, sync2_q;
    logic [3:0]       samp_q;           // value currently being qualified
    logic [CNT_W-1:0] cnt_q;            // consecutive cycles samp_q has been seen
    logic [3:0]       acc_q;            // last accepted pattern
    logic             accept;

    // A pattern is accepted once: after it has been stable long enough and only
    // if it differs from the previously accepted one.
    assign accept = (cnt_q == CNT_W'(STABLE_CYC)) && (samp_q != acc_q);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, giving true pipeline behaviour.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            samp_q  <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            sync1_q <= coil_in;
            sync2_q <= sync1_q;
            if (sync2_q != samp_q) begin
                samp_q <= sync2_q;
                cnt_q  <= CNT_W'(1);
            end else if (cnt_q != CNT_W'(STABLE_CYC)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (accept) begin
                acc_q <= samp_q;
            end
        end
    end

    // Lock / step classification
    state_e           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             step_q, step_d;
    logic             fault_q, fault_d;
    logic             dir_q, dir_d;
    logic             half_q, half_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;

    logic       new_valid;
    logic [2:0] new_idx;
    logic [2:0] diff;

    assign {new_valid, new_idx} = decode(samp_q);
    // Modulo-8 distance around the eight-entry phase ring.
    assign diff = new_idx - idx_q;

    // NOTE: every output of this block receives a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pos_d   = pos_q;
        step_d  = 1'b0;
        fault_d = 1'b0;
        dir_d   = dir_q;
        half_d  = half_q;

        if (accept) begin
            case (state_q)
                UNLOCKED: begin
                    if (new_valid) begin
                        state_d = LOCKED;
                        idx_d   = new_idx;
                    end else begin
                        fault_d = 1'b1;
                    end
                end
                LOCKED: begin
                    if (!new_valid) begin
                        fault_d = 1'b1;
                        state_d = UNLOCKED;
                    end else begin
                        case (diff)
                            3'd1: begin
                                pos_d  = pos_q + POS_W'(1);
                                dir_d  = 1'b1;
                                half_d = 1'b1;
                                step_d = 1'b1;
                                idx_d  = new_idx;
                            end
                            3'd7: begin
                                pos_d  = pos_q - POS_W'(1);
                                dir_d  = 1'b0;
                                half_d = 1'b1;
                                step_d = 1'b1;
                                idx_d  = new_idx;
                            end
                            3'd2: begin
                                pos_d  = pos_q + POS_W'(2);
                                dir_d  = 1'b1;
                                half_d = 1'b0;
                                step_d = 1'b1;
                                idx_d  = new_idx;
                            end
                            3'd6: begin
                                pos_d  = pos_q - POS_W'(2);
                                dir_d  = 1'b0;
                                half_d = 1'b0;
                                step_d = 1'b1;
                                idx_d  = new_idx;
                            end
                            3'd3, 3'd4, 3'd5: begin
                                // Skipped too far to tell direction: drop the lock.
                                fault_d = 1'b1;
                                state_d = UNLOCKED;
                            end
                            default: begin
                                // Same index: cannot occur, an accepted code always differs.
                            end
                        endcase
                    end
                end
                default: begin
                    state_d = UNLOCKED;
                end
            endcase
        end

        if (clear_pos) begin
            pos_d = '0;
        end

        fcnt_d = (fault_d && (fcnt_q != '1)) ? fcnt_q + FCNT_W'(1) : fcnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= UNLOCKED;
            idx_q   <= '0;
            pos_q   <= '0;
            step_q  <= 1'b0;
            fault_q <= 1'b0;
            dir_q   <= 1'b1;
            half_q  <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            step_q  <= step_d;
            fault_q <= fault_d;
            dir_q   <= dir_d;
            half_q  <= half_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign position    = pos_q;
    assign step_pulse  = step_q;
    assign dir_cw      = dir_q;
    assign half_mode   = half_q;
    assign locked      = (state_q == LOCKED);
    assign fault       = fault_q;
    assign fault_count = fcnt_q;

endmodule
